test_pattern_send: RTL and testbench

// - Traffic source of the MAC loopback test: emits Ethernet frames with a fixed, checkable payload pattern.
// - Each payload carries a 16-bit tx timestamp and packet index, so the receive-side checker can verify data and measure latency.
// - Sits upstream of the pattern checker, driving the MAC TX eth header/payload AXI-stream interface.

---
 rtl/test_pattern_send.sv | 258 +++++++++++++++++++++++++
 tb/tb_test_pattern_send.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_send.sv
// -----------------------------------------------------------------------------
// test_pattern_send
//
// Traffic source for the MAC loopback test. Emits Ethernet frames whose
// payload follows a fixed, checkable pattern carrying a 16-bit tx timestamp
// and the packet index. The receive-side checker uses these to verify the
// data and measure latency.
//
// Payload byte i of a frame:
//   i=0 ts_q[7:0]   i=1 ts_q[15:8]   i=2 index[7:0]   i=3 index[15:8]
//   i>=4 (i + index[7:0]) mod 256
// where ts_q is the timestamp captured when the header is accepted.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              1 = send frames; 0 = stop after the current frame
//   gap_cycles          idle cycles between a tlast beat and the next header
//   packet_limit        frames to send (0 = unlimited)
//   src_mac, dst_mac    copied into the header fields
//   timestamp           free-running time base
//   packet_index        index of the current/next frame
//   done                packet_limit frames sent (sticky until rst)
//   busy                FSM not idle
//   m_eth_hdr_*         header handshake and fields
//   m_eth_payload_axis_* payload AXI-stream (tuser always 0)
//
// Optional build macro: TEST_PATTERN_SEND_ERR_INJ_EN
//   Adds input err_inj. A 0->1 edge arms a one-shot; the next payload byte
//   with i>=4 is sent with tdata bit 0 inverted, then the one-shot clears.
//
// DATA_WIDTH only supports 8; DATA_LENGTH must be in 4..1500.
// -----------------------------------------------------------------------------
module test_pattern_send #(
  parameter int          DATA_LENGTH = 64,
  parameter int          DATA_WIDTH  = 8,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [15:0]           gap_cycles,
  input  logic [15:0]           packet_limit,
  input  logic [47:0]           src_mac,
  input  logic [47:0]           dst_mac,
  input  logic [15:0]           timestamp,
`ifdef TEST_PATTERN_SEND_ERR_INJ_EN
  input  logic                  err_inj,
`endif
  output logic [15:0]           packet_index,
  output logic                  done,
  output logic                  busy,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser
);

  localparam int CNT_W = $clog2(DATA_LENGTH);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(DATA_LENGTH - 1);
  localparam logic [CNT_W-1:0] PATTERN_IDX = CNT_W'(4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [15:0]      ts_q_reg, ts_q_next;
  logic [15:0]      index_reg, index_next;
  logic             done_reg, done_next;
  logic             tlast_reg, tlast_next;
  logic [7:0]       tdata_reg, tdata_next;
  logic [47:0]      dest_reg, dest_next;
  logic [47:0]      src_reg, src_next;
  logic             hdr_load;

`ifdef TEST_PATTERN_SEND_ERR_INJ_EN
  logic err_inj_d_reg;
  logic armed_reg, armed_next;
  logic armed_eff;

  // An edge arriving in the same cycle a byte is loaded still counts.
  assign armed_eff = armed_reg | (err_inj & ~err_inj_d_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_inj_d_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      err_inj_d_reg <= err_inj;
      armed_reg     <= armed_next;
    end
  end
`endif

  // Payload pattern for byte i of the current frame.
  function automatic logic [7:0] pattern_byte(
    input logic [CNT_W-1:0] i,
    input logic [15:0]      ts,
    input logic [15:0]      idx
  );
    logic [7:0] i8;
    i8 = 8'(i);
    case (i8)
      8'd0:    pattern_byte = ts[7:0];
      8'd1:    pattern_byte = ts[15:8];
      8'd2:    pattern_byte = idx[7:0];
      8'd3:    pattern_byte = idx[15:8];
      default: pattern_byte = i8 + idx[7:0];
    endcase
    // Bytes 0..3 never collide with i>=4 because i8 only aliases above 255.
    if (i >= PATTERN_IDX) pattern_byte = i8 + idx[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      gap_cnt_reg  <= 16'd0;
      byte_cnt_reg <= '0;
      ts_q_reg     <= 16'd0;
      index_reg    <= 16'd0;
      done_reg     <= 1'b0;
      tlast_reg    <= 1'b0;
      tdata_reg    <= 8'd0;
      dest_reg     <= 48'd0;
      src_reg      <= 48'd0;
    end else begin
      state_reg    <= state_next;
      gap_cnt_reg  <= gap_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      ts_q_reg     <= ts_q_next;
      index_reg    <= index_next;
      done_reg     <= done_next;
      tlast_reg    <= tlast_next;
      tdata_reg    <= tdata_next;
      dest_reg     <= dest_next;
      src_reg      <= src_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gap_cnt_next  = gap_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    ts_q_next     = ts_q_reg;
    index_next    = index_reg;
    done_next     = done_reg;
    tlast_next    = tlast_reg;
    tdata_next    = tdata_reg;
    hdr_load      = 1'b0;
`ifdef TEST_PATTERN_SEND_ERR_INJ_EN
    armed_next    = armed_eff;
`endif

    case (state_reg)
      S_IDLE: begin
        if (enable && !done_reg) begin
          state_next = S_HDR;
          hdr_load   = 1'b1;
        end
      end

      S_HDR: begin
        if (m_eth_hdr_ready) begin
          // Byte 0 is the low timestamp byte taken in this same cycle.
          state_next    = S_PAYLOAD;
          ts_q_next     = timestamp;
          byte_cnt_next = '0;
          tdata_next    = timestamp[7:0];
          tlast_next    = 1'b0;
        end
      end

      S_PAYLOAD: begin
        if (m_eth_payload_axis_tready) begin
          if (tlast_reg) begin
            index_next    = index_reg + 16'd1;
            if ((packet_limit != 16'd0) && (index_next == packet_limit)) begin
              done_next = 1'b1;
            end
            tlast_next    = 1'b0;
            tdata_next    = 8'd0;
            byte_cnt_next = '0;
            if (gap_cycles == 16'd0) begin
              // Zero gap: decide restart now, using the freshly updated done.
              if (enable && !done_next) begin
                state_next = S_HDR;
                hdr_load   = 1'b1;
              end else begin
                state_next = S_IDLE;
              end
            end else begin
              state_next   = S_GAP;
              gap_cnt_next = 16'd1;
            end
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
            tdata_next    = pattern_byte(byte_cnt_next, ts_q_reg, index_reg);
            tlast_next    = (byte_cnt_next == LAST_IDX);
`ifdef TEST_PATTERN_SEND_ERR_INJ_EN
            // The corrupted byte is loaded here and, since nothing but rst
            // aborts a frame, it is guaranteed to be the next accepted one.
            if (armed_eff && (byte_cnt_next >= PATTERN_IDX)) begin
              tdata_next[0] = ~tdata_next[0];
              armed_next    = 1'b0;
            end
`endif
          end
        end
      end

      S_GAP: begin
        // >= so a gap_cycles reduced mid-gap still ends the gap.
        if (gap_cnt_reg >= gap_cycles) begin
          gap_cnt_next = 16'd0;
          if (enable && !done_reg) begin
            state_next = S_HDR;
            hdr_load   = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Header fields are captured on entry to HDR so they stay stable while
    // the header waits for acceptance.
    dest_next = hdr_load ? dst_mac : dest_reg;
    src_next  = hdr_load ? src_mac : src_reg;
  end

  assign packet_index              = index_reg;
  assign done                      = done_reg;
  assign busy                      = (state_reg != S_IDLE);
  assign m_eth_hdr_valid           = (state_reg == S_HDR);
  assign m_eth_dest_mac            = dest_reg;
  assign m_eth_src_mac             = src_reg;
  assign m_eth_type                = ETH_TYPE;
  assign m_eth_payload_axis_tdata  = tdata_reg;
  assign m_eth_payload_axis_tvalid = (state_reg == S_PAYLOAD);
  assign m_eth_payload_axis_tlast  = tlast_reg;
  assign m_eth_payload_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_test_pattern_send.sv
// -----------------------------------------------------------------------------
// tb_test_pattern_send
//
// Directed self-checking bench for test_pattern_send (DATA_LENGTH=64).
// A negedge monitor records accepted payload beats, header acceptances and
// stall stability; scenario tasks drive stimulus and compare against
// hand-computed values and the payload pattern formula.
// -----------------------------------------------------------------------------
module tb_test_pattern_send;

  localparam int LEN = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] gap_cycles = 16'd0;
  logic [15:0] packet_limit = 16'd0;
  logic [47:0] src_mac = 48'h0A0B0C0D0E0F;
  logic [47:0] dst_mac = 48'h112233445566;
  logic [15:0] timestamp = 16'd0;
  logic [15:0] packet_index;
  logic        done;
  logic        busy;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [47:0] m_dst;
  logic [47:0] m_src;
  logic [15:0] m_type;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        tuser;
`ifdef TEST_PATTERN_SEND_ERR_INJ_EN
  logic        err_inj = 1'b0;
`endif

  test_pattern_send dut (
    .clk                       (clk),
    .rst                       (rst),
    .enable                    (enable),
    .gap_cycles                (gap_cycles),
    .packet_limit              (packet_limit),
    .src_mac                   (src_mac),
    .dst_mac                   (dst_mac),
    .timestamp                 (timestamp),
`ifdef TEST_PATTERN_SEND_ERR_INJ_EN
    .err_inj                   (err_inj),
`endif
    .packet_index              (packet_index),
    .done                      (done),
    .busy                      (busy),
    .m_eth_hdr_valid           (hdr_valid),
    .m_eth_hdr_ready           (hdr_ready),
    .m_eth_dest_mac            (m_dst),
    .m_eth_src_mac             (m_src),
    .m_eth_type                (m_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Ready and timestamp drivers
  bit          rand_bp = 1'b0;
  bit          ts_free = 1'b1;
  logic [15:0] ts_hold = 16'd0;

  always @(posedge clk) begin
    #1;
    if (rand_bp) begin
      tready    = ($urandom_range(0, 3) != 0);
      hdr_ready = ($urandom_range(0, 2) != 0);
    end else begin
      tready    = 1'b1;
      hdr_ready = 1'b1;
    end
    timestamp = ts_free ? timestamp + 16'd1 : ts_hold;
  end

  // Monitor
  logic [7:0]  bd[$];
  bit          bl[$];
  int          last_cyc[$];
  int          hdr_start[$];
  logic [15:0] hdr_ts[$];
  int          hdr_acc = 0;
  int          stab_err = 0;
  int          cycle = 0;
  bit          stall_prev = 0, hstall_prev = 0, hdr_prev = 0;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic [47:0] prev_dst, prev_src;

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      stall_prev  = 0;
      hstall_prev = 0;
      hdr_prev    = 0;
    end else begin
      if (stall_prev && (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last))
        stab_err++;
      if (hstall_prev && (hdr_valid !== 1'b1 || m_dst !== prev_dst || m_src !== prev_src))
        stab_err++;
      if (hdr_valid && !hdr_prev) hdr_start.push_back(cycle);
      if (hdr_valid && hdr_ready) begin
        hdr_ts.push_back(timestamp);
        hdr_acc++;
      end
      if (tvalid && tready) begin
        bd.push_back(tdata);
        bl.push_back(tlast);
        if (tlast) last_cyc.push_back(cycle);
      end
      stall_prev  = tvalid && !tready;
      hstall_prev = hdr_valid && !hdr_ready;
      prev_data   = tdata;
      prev_last   = tlast;
      prev_dst    = m_dst;
      prev_src    = m_src;
      hdr_prev    = hdr_valid;
    end
  end

  // Expected payload byte from the frame pattern definition.
  function automatic logic [7:0] exp_byte(input int i, input logic [15:0] ts,
                                          input logic [15:0] idx);
    case (i)
      0:       exp_byte = ts[7:0];
      1:       exp_byte = ts[15:8];
      2:       exp_byte = idx[7:0];
      3:       exp_byte = idx[15:8];
      default: exp_byte = 8'(i + int'(idx[7:0]));
    endcase
  endfunction

  // Number of bytes/tlast flags in a recorded frame that differ from the pattern.
  function automatic int frame_errors(input int base, input logic [15:0] ts,
                                      input logic [15:0] idx);
    int e = 0;
    for (int i = 0; i < LEN; i++) begin
      if (base + i >= bd.size()) e++;
      else begin
        if (bd[base+i] !== exp_byte(i, ts, idx)) e++;
        if (bl[base+i] !== (i == LEN - 1)) e++;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bd.delete();
    bl.delete();
    last_cyc.delete();
    hdr_start.delete();
    hdr_ts.delete();
    hdr_acc  = 0;
    stab_err = 0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    enable  = 1'b0;
    rand_bp = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_beats(input int n, output bit ok);
    int c = 0;
    while (bd.size() < n && c < 5000) begin
      tick();
      c++;
    end
    ok = (bd.size() >= n);
  endtask

  task automatic wait_done(output bit ok);
    int c = 0;
    while (done !== 1'b1 && c < 5000) begin
      tick();
      c++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic wait_not_busy(output bit ok);
    int c = 0;
    while (busy !== 1'b0 && c < 5000) begin
      tick();
      c++;
    end
    ok = (busy === 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({hdr_valid, tvalid, tlast, tuser, done, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000", {hdr_valid, tvalid, tlast, tuser, done, busy});
    else passes++;
    checks++;
    if (packet_index !== 16'd0) $display("FAIL reset_index: got %h required 0000", packet_index);
    else passes++;
    checks++;
    if (tdata !== 8'd0) $display("FAIL reset_tdata: got %h required 00", tdata);
    else passes++;
    checks++;
    if (m_type !== 16'h88B5) $display("FAIL eth_type: got %h required 88b5", m_type);
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_three_frames();
    bit ok;
    int e = 0;
    do_reset();
    ts_free = 1'b1;
    gap_cycles = 16'd5;
    packet_limit = 16'd3;
    enable = 1'b1;
    wait_done(ok);
    repeat (20) tick();
    checks++;
    if (!ok) $display("FAIL three_done_timeout: done=%b required 1", done);
    else passes++;
    checks++;
    if (bd.size() !== 3 * LEN) $display("FAIL three_beats: got %0d required %0d", bd.size(), 3 * LEN);
    else passes++;
    checks++;
    if (hdr_acc !== 3) $display("FAIL three_hdrs: got %0d required 3", hdr_acc);
    else passes++;
    if (hdr_ts.size() >= 3) begin
      for (int f = 0; f < 3; f++) e += frame_errors(f * LEN, hdr_ts[f], 16'(f));
    end else e = -1;
    checks++;
    if (e !== 0) $display("FAIL three_payload: bad bytes %0d required 0", e);
    else passes++;
    for (int k = 0; k < 2; k++) begin
      int idle;
      idle = (hdr_start.size() > k + 1 && last_cyc.size() > k) ?
             hdr_start[k+1] - last_cyc[k] - 1 : -1;
      checks++;
      if (idle !== 5) $display("FAIL three_gap%0d: got %0d idle cycles required 5", k, idle);
      else passes++;
    end
    checks++;
    if (packet_index !== 16'd3) $display("FAIL three_index: got %0d required 3", packet_index);
    else passes++;
    checks++;
    if ({done, busy, hdr_valid} !== 3'b100)
      $display("FAIL three_final: done/busy/hdr_valid got %b required 100", {done, busy, hdr_valid});
    else passes++;
    $display("test_three_frames: %0d beats, %0d headers", bd.size(), hdr_acc);
  endtask

  task automatic test_frame1_values();
    bit ok;
    int          pos[6] = '{64, 65, 66, 67, 68, 127};
    logic [7:0]  val[6] = '{8'h34, 8'h12, 8'h01, 8'h00, 8'h05, 8'h40};
    int tl = 0;
    int idle;
    do_reset();
    ts_free = 1'b0;
    ts_hold = 16'h1234;
    gap_cycles = 16'd0;
    packet_limit = 16'd2;
    tick();
    enable = 1'b1;
    wait_done(ok);
    repeat (5) tick();
    checks++;
    if (!ok || bd.size() !== 2 * LEN)
      $display("FAIL f1_beats: got %0d beats required %0d", bd.size(), 2 * LEN);
    else passes++;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] got;
      got = (bd.size() > pos[k]) ? bd[pos[k]] : 8'hxx;
      checks++;
      if (got !== val[k]) $display("FAIL f1_byte%0d: got %h required %h", pos[k] - LEN, got, val[k]);
      else passes++;
    end
    for (int i = LEN; i < bl.size(); i++) if (bl[i]) tl++;
    checks++;
    if (tl !== 1 || bl.size() < 2 * LEN || bl[2*LEN-1] !== 1'b1)
      $display("FAIL f1_tlast: got %0d tlast beats required 1 on byte63", tl);
    else passes++;
    idle = (hdr_start.size() > 1 && last_cyc.size() > 0) ? hdr_start[1] - last_cyc[0] - 1 : -1;
    checks++;
    if (idle !== 0) $display("FAIL f1_zero_gap: got %0d idle cycles required 0", idle);
    else passes++;
    ts_free = 1'b1;
    $display("test_frame1_values: %0d beats", bd.size());
  endtask

  task automatic test_backpressure();
    bit ok;
    int e;
    int tl = 0;
    do_reset();
    ts_free = 1'b0;
    ts_hold = 16'h5A5A;
    gap_cycles = 16'd3;
    packet_limit = 16'd2;
    tick();
    rand_bp = 1'b1;
    enable = 1'b1;
    wait_done(ok);
    rand_bp = 1'b0;
    repeat (10) tick();
    checks++;
    if (!ok) $display("FAIL bp_done_timeout: done=%b required 1", done);
    else passes++;
    checks++;
    if (bd.size() !== 2 * LEN) $display("FAIL bp_beats: got %0d required %0d", bd.size(), 2 * LEN);
    else passes++;
    e = frame_errors(0, 16'h5A5A, 16'd0) + frame_errors(LEN, 16'h5A5A, 16'd1);
    checks++;
    if (e !== 0) $display("FAIL bp_payload: bad bytes %0d required 0", e);
    else passes++;
    checks++;
    if (stab_err !== 0) $display("FAIL bp_stability: got %0d changes while stalled required 0", stab_err);
    else passes++;
    foreach (bl[i]) if (bl[i]) tl++;
    checks++;
    if (tl !== 2) $display("FAIL bp_tlast_count: got %0d required 2", tl);
    else passes++;
    ts_free = 1'b1;
    $display("test_backpressure: %0d beats, %0d stall errors", bd.size(), stab_err);
  endtask

  task automatic test_enable_drop();
    bit ok1, ok2;
    int e;
    do_reset();
    ts_free = 1'b1;
    gap_cycles = 16'd4;
    packet_limit = 16'd0;
    enable = 1'b1;
    wait_beats(10, ok1);
    enable = 1'b0;
    wait_not_busy(ok2);
    repeat (30) tick();
    checks++;
    if (!ok1 || !ok2) $display("FAIL ed_timeout: beats_ok=%b idle_ok=%b required 1 1", ok1, ok2);
    else passes++;
    checks++;
    if (bd.size() !== LEN) $display("FAIL ed_beats: got %0d required %0d", bd.size(), LEN);
    else passes++;
    e = (hdr_ts.size() > 0) ? frame_errors(0, hdr_ts[0], 16'd0) : -1;
    checks++;
    if (e !== 0) $display("FAIL ed_payload: bad bytes %0d required 0", e);
    else passes++;
    checks++;
    if (hdr_start.size() !== 1 || hdr_acc !== 1)
      $display("FAIL ed_headers: got %0d/%0d required 1/1", hdr_start.size(), hdr_acc);
    else passes++;
    checks++;
    if ({busy, done, hdr_valid, tvalid} !== 4'b0 || packet_index !== 16'd1)
      $display("FAIL ed_final: busy/done/hdr/tvalid %b index %0d required 0000 index 1",
               {busy, done, hdr_valid, tvalid}, packet_index);
    else passes++;
    $display("test_enable_drop: %0d beats, %0d headers", bd.size(), hdr_acc);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e;
    do_reset();
    ts_free = 1'b1;
    gap_cycles = 16'd2;
    packet_limit = 16'd0;
    enable = 1'b1;
    wait_beats(LEN + 20, ok);
    checks++;
    if (!ok || packet_index !== 16'd1)
      $display("FAIL rm_pre: beats_ok=%b index %0d required 1 1", ok, packet_index);
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tvalid, hdr_valid, tlast} !== 3'b0 || packet_index !== 16'd0)
      $display("FAIL rm_after_rst: tvalid/hdr/tlast %b index %0d required 000 index 0",
               {tvalid, hdr_valid, tlast}, packet_index);
    else passes++;
    tick();
    rst = 1'b0;
    clear_mon();
    wait_beats(LEN, ok);
    e = (ok && hdr_ts.size() > 0) ? frame_errors(0, hdr_ts[0], 16'd0) : -1;
    checks++;
    if (e !== 0) $display("FAIL rm_restart_frame: bad bytes %0d required 0", e);
    else passes++;
    enable = 1'b0;
    $display("test_reset_mid: restart frame %0d beats", bd.size());
  endtask

`ifdef TEST_PATTERN_SEND_ERR_INJ_EN
  task automatic test_err_inj();
    bit ok;
    int c = 0;
    int e0, e1;
    do_reset();
    ts_free = 1'b1;
    gap_cycles = 16'd0;
    packet_limit = 16'd2;
    enable = 1'b1;
    while (hdr_valid !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    wait_done(ok);
    repeat (5) tick();
    checks++;
    if (!ok || bd.size() !== 2 * LEN) $display("FAIL ei_beats: got %0d required %0d", bd.size(), 2 * LEN);
    else passes++;
    checks++;
    if (bd.size() < 5 || bd[4] !== 8'h05) $display("FAIL ei_byte4_f0: got %h required 05", bd.size() > 4 ? bd[4] : 8'hxx);
    else passes++;
    checks++;
    if (bd.size() < LEN + 5 || bd[LEN+4] !== 8'h05)
      $display("FAIL ei_byte4_f1: got %h required 05", bd.size() > LEN + 4 ? bd[LEN+4] : 8'hxx);
    else passes++;
    e0 = (hdr_ts.size() > 1) ? frame_errors(0, hdr_ts[0], 16'd0) : -1;
    e1 = (hdr_ts.size() > 1) ? frame_errors(LEN, hdr_ts[1], 16'd1) : -1;
    checks++;
    if (e0 !== 1 || e1 !== 0) $display("FAIL ei_only_one: bad bytes f0=%0d f1=%0d required 1 0", e0, e1);
    else passes++;
    $display("test_err_inj: %0d beats", bd.size());
  endtask
`endif

  initial begin
    test_reset();
    test_three_frames();
    test_frame1_values();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
`ifdef TEST_PATTERN_SEND_ERR_INJ_EN
    test_err_inj();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
